// File: rtl/gelato_types.sv
// Shared GELATO types: warp count, warp-number width and the decoded instruction
// record that travels from decode through the instruction buffer to issue.
package gelato_types;

    localparam int NUM_WARPS = 4;
    localparam int WARP_W    = $clog2(NUM_WARPS);

    typedef logic [WARP_W-1:0] warp_num_t;

    typedef struct packed {
        warp_num_t   warp_num;
        logic [7:0]  opcode;
        logic [31:0] pc;
    } inst_t;

endpackage

// File: rtl/gelato_warp_fifo.sv
// Single-warp instruction FIFO with write, pop and flush; flush beats both, and a
// write to a full FIFO only lands when the same cycle also pops.
module gelato_warp_fifo
    import gelato_types::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  inst_t            wdata_i,
    output inst_t            head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    inst_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign wr_ok  = wr_i && (!full_o || pop_i) && !flush_i;
    assign pop_ok = pop_i && (count_q != '0) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (en_i) begin
            if (flush_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (wr_ok)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
                case ({wr_ok, pop_ok})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (en_i && wr_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer between decode and issue, with a round-robin
// picker over warps that are non-empty, scoreboard-ready and not being flushed.
module gelato_inst_buffer
    import gelato_types::*;
#(
    parameter  int NUM_WARPS = gelato_types::NUM_WARPS,
    parameter  int DEPTH     = 4,
    localparam int WW        = $clog2(NUM_WARPS),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_valid,
    input  inst_t                in_inst,
    output logic [NUM_WARPS-1:0] warp_full,
    output logic [NUM_WARPS-1:0] warp_empty,
    input  logic [NUM_WARPS-1:0] warp_ready,
    output logic                 out_valid,
    output inst_t                out_inst,
    input  logic                 out_ready,
    input  logic                 flush_valid,
    input  logic [WW-1:0]        flush_warp,
    output logic                 err_overflow
);

    logic [NUM_WARPS-1:0] wr_sel;
    logic [NUM_WARPS-1:0] pop_sel;
    logic [NUM_WARPS-1:0] flush_sel;
    logic [NUM_WARPS-1:0] elig;
    logic [CNT_W-1:0]     count [NUM_WARPS];
    inst_t                head  [NUM_WARPS];
    logic [WW-1:0]        rr_q, rr_d;
    logic [WW-1:0]        grant;
    logic                 any_elig;
    logic                 ovf;
    logic                 err_q, err_d;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        gelato_warp_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .en_i    (rdy),
            .wr_i    (wr_sel[w]),
            .pop_i   (pop_sel[w]),
            .flush_i (flush_sel[w]),
            .wdata_i (in_inst),
            .head_o  (head[w]),
            .count_o (count[w]),
            .full_o  (warp_full[w])
        );
        assign warp_empty[w] = (count[w] == '0);
    end

    always_comb begin
        wr_sel    = '0;
        flush_sel = '0;
        elig      = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            wr_sel[w]    = in_valid && (in_inst.warp_num == WARP_W'(w));
            flush_sel[w] = flush_valid && (flush_warp == WW'(w));
            elig[w]      = (count[w] != '0) && warp_ready[w] && !flush_sel[w];
        end
    end

    // Search starts just after the last granted warp so every ready warp gets a turn.
    always_comb begin
        grant    = '0;
        any_elig = 1'b0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            if (!any_elig && elig[(int'(rr_q) + i) % NUM_WARPS]) begin
                any_elig = 1'b1;
                grant    = WW'((int'(rr_q) + i) % NUM_WARPS);
            end
        end
    end

    assign out_valid = rdy && any_elig;
    assign out_inst  = head[grant];

    always_comb begin
        pop_sel = '0;
        ovf     = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pop_sel[w] = out_valid && out_ready && (grant == WW'(w));
            ovf        = ovf | (wr_sel[w] && warp_full[w] && !pop_sel[w] && !flush_sel[w]);
        end
    end

    always_comb begin
        rr_d  = rr_q;
        err_d = err_q;
        if (rdy) begin
            if (out_valid && out_ready) rr_d = grant;
            if (ovf) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= WW'(NUM_WARPS - 1);
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    assign err_overflow = err_q;

endmodule

// File: tb/tb_gelato_inst_buffer.sv
// Directed bench for gelato_inst_buffer: expected issue order is queued as stimulus
// is applied and an independent monitor compares every accepted instruction.
module tb_gelato_inst_buffer;
    import gelato_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_valid;
    inst_t       in_inst;
    logic [3:0]  warp_full;
    logic [3:0]  warp_empty;
    logic [3:0]  warp_ready;
    logic        out_valid;
    inst_t       out_inst;
    logic        out_ready;
    logic        flush_valid;
    logic [1:0]  flush_warp;
    logic        err_overflow;

    int    checks = 0;
    int    errors = 0;
    inst_t sb [$];

    gelato_inst_buffer #(.NUM_WARPS(4), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .in_valid     (in_valid),
        .in_inst      (in_inst),
        .warp_full    (warp_full),
        .warp_empty   (warp_empty),
        .warp_ready   (warp_ready),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_ready    (out_ready),
        .flush_valid  (flush_valid),
        .flush_warp   (flush_warp),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    function automatic inst_t mk(input int w, input logic [31:0] pc);
        inst_t t;
        t.warp_num = 2'(w);
        t.opcode   = 8'(pc[7:0] ^ 8'h5A);
        t.pc       = pc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_inst = '0;
        warp_ready = 4'hF; out_ready = 1'b0; flush_valid = 1'b0; flush_warp = '0;
        cyc(); cyc();
        rst = 1'b0;
        sb.delete();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_empty", 64'(warp_empty), 64'hF);
        chk("rst_full", 64'(warp_full), 64'h0);
        chk("rst_err", 64'(err_overflow), 64'd0);
    endtask

    task automatic wr(input int w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = mk(w, pc);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int w, input string name);
        int n = 0;
        while (!warp_empty[w] && n < 40) begin
            cyc();
            n++;
        end
        chk(name, 64'(warp_empty[w]), 64'd1);
        cyc();
        chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every accepted issue must match the head of the expected queue.
    initial begin
        inst_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h required=none", out_inst);
                end else begin
                    e = sb.pop_front();
                    chk("sb_issue", 64'(out_inst), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // In-order issue from one warp, one-cycle write-to-issue latency.
        out_ready = 1'b1;
        sb.push_back(mk(1, 32'h100));
        sb.push_back(mk(1, 32'h104));
        sb.push_back(mk(1, 32'h108));
        in_valid = 1'b1;
        in_inst  = mk(1, 32'h100);
        #2 chk("latency_first", 64'(out_valid), 64'd0);
        cyc();
        in_inst = mk(1, 32'h104);
        cyc();
        in_inst = mk(1, 32'h108);
        cyc();
        in_valid = 1'b0;
        wait_empty(1, "inorder_empty1");

        // Overflow on a full, non-popped warp.
        do_reset();
        for (int i = 0; i < 4; i++) wr(0, 32'h200 + 32'(4 * i));
        chk("fill_full0", 64'(warp_full[0]), 64'd1);
        chk("fill_err", 64'(err_overflow), 64'd0);
        wr(0, 32'h210);
        chk("ovf_err", 64'(err_overflow), 64'd1);
        chk("ovf_full0", 64'(warp_full[0]), 64'd1);
        for (int i = 0; i < 4; i++) sb.push_back(mk(0, 32'h200 + 32'(4 * i)));
        out_ready = 1'b1;
        wait_empty(0, "ovf_drain");
        chk("ovf_err_sticky", 64'(err_overflow), 64'd1);

        // Write to a full warp that pops the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) wr(0, 32'h300 + 32'(4 * i));
        for (int i = 0; i < 5; i++) sb.push_back(mk(0, 32'h300 + 32'(4 * i)));
        in_valid  = 1'b1;
        in_inst   = mk(0, 32'h310);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("wrpop_full0", 64'(warp_full[0]), 64'd1);
        chk("wrpop_err", 64'(err_overflow), 64'd0);
        wait_empty(0, "wrpop_drain");

        // Round-robin across warps 0,1,2.
        do_reset();
        wr(0, 32'h400); wr(0, 32'h404);
        wr(1, 32'h410); wr(1, 32'h414);
        wr(2, 32'h420); wr(2, 32'h424);
        sb.push_back(mk(0, 32'h400)); sb.push_back(mk(1, 32'h410)); sb.push_back(mk(2, 32'h420));
        sb.push_back(mk(0, 32'h404)); sb.push_back(mk(1, 32'h414)); sb.push_back(mk(2, 32'h424));
        out_ready = 1'b1;
        wait_empty(2, "rr_drain");

        // Flush beats same-cycle write and pop to the same warp.
        do_reset();
        wr(2, 32'h500); wr(2, 32'h504); wr(2, 32'h508);
        flush_valid = 1'b1;
        flush_warp  = 2'd2;
        in_valid    = 1'b1;
        in_inst     = mk(2, 32'h5FF);
        out_ready   = 1'b1;
        #2 chk("flush_no_issue", 64'(out_valid), 64'd0);
        cyc();
        flush_valid = 1'b0;
        in_valid    = 1'b0;
        chk("flush_empty2", 64'(warp_empty[2]), 64'd1);
        chk("flush_err", 64'(err_overflow), 64'd0);
        cyc();
        chk("flush_idle", 64'(out_valid), 64'd0);
        chk("flush_sb", 64'(sb.size()), 64'd0);

        // Scoreboard-blocked warp is skipped until released.
        do_reset();
        warp_ready = 4'b1101;
        wr(1, 32'h600); wr(3, 32'h700); wr(3, 32'h704);
        sb.push_back(mk(3, 32'h700));
        sb.push_back(mk(3, 32'h704));
        out_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("blocked_idle", 64'(out_valid), 64'd0);
        chk("blocked_keep1", 64'(warp_empty[1]), 64'd0);
        sb.push_back(mk(1, 32'h600));
        warp_ready = 4'hF;
        wait_empty(1, "release_drain");

        // rdy low freezes everything.
        do_reset();
        wr(0, 32'h800);
        rdy         = 1'b0;
        in_valid    = 1'b1;
        in_inst     = mk(0, 32'h804);
        flush_valid = 1'b1;
        flush_warp  = 2'd0;
        out_ready   = 1'b1;
        #2 chk("stall_no_valid", 64'(out_valid), 64'd0);
        cyc(); cyc();
        in_valid    = 1'b0;
        flush_valid = 1'b0;
        chk("stall_kept0", 64'(warp_empty[0]), 64'd0);
        sb.push_back(mk(0, 32'h800));
        rdy = 1'b1;
        wait_empty(0, "stall_drain");

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gelato_inst_buffer.md
GELATO_INST_BUFFER -- requirements
Module: gelato_inst_buffer

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, the number of warps, each with a private FIFO.
REQ-002 SHALL have parameter DEPTH, default 4, the entries per warp FIFO (power of two, >=2).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rdy  input  1  global enable; low freezes all state.
REQ-007 in_valid  input  1  decoded instruction present this cycle (from decode stage).
REQ-008 in_inst  input  inst_t  decoded instruction; in_inst.warp_num selects the FIFO.
REQ-009 warp_full  output  NUM_WARPS  per-warp FIFO full; fetch SHALL NOT fetch for a full warp.
REQ-010 warp_empty  output  NUM_WARPS  per-warp FIFO empty.
REQ-011 warp_ready  input  NUM_WARPS  per-warp issue permission (scoreboard clear).
REQ-012 out_valid  output  1  out_inst is valid for issue.
REQ-013 out_inst  output  inst_t  head instruction of the granted warp.
REQ-014 out_ready  input  1  issue stage accepts out_inst this cycle.
REQ-015 flush_valid  input  1  discard all entries of warp flush_warp.
REQ-016 flush_warp  input  $clog2(NUM_WARPS)  warp to flush.
REQ-017 err_overflow  output  1  sticky: a write hit a full FIFO.

Function
REQ-018 SHALL append in_inst to FIFO[in_inst.warp_num] when rdy && in_valid and that FIFO is not full after any same-cycle pop.
REQ-019 SHALL accept a write to a full FIFO when the same FIFO is popped in the same cycle; count stays DEPTH.
REQ-020 SHALL drop a write to a full, non-popped FIFO, leave contents unchanged, and set err_overflow.
REQ-021 SHALL make a written entry visible at out_inst no earlier than the cycle after the write (one-cycle minimum latency).
REQ-022 SHALL mark warp w eligible when count[w] != 0, warp_ready[w] == 1, and w is not being flushed this cycle.
REQ-023 SHALL grant the first eligible warp, searching round-robin from rr_ptr+1 upward modulo NUM_WARPS.
REQ-024 SHALL drive out_valid = rdy && (any warp eligible), out_inst = head of the granted FIFO (combinational from registered state).
REQ-025 SHALL pop the granted FIFO and set rr_ptr to the granted warp on out_valid && out_ready; rr_ptr SHALL hold otherwise.
REQ-026 SHALL hold out_inst stable while out_valid && !out_ready, unless warp_ready or a flush changes eligibility.
REQ-027 SHALL on flush_valid && rdy clear count, rd_ptr, and wr_ptr of flush_warp; flush SHALL take priority over a same-cycle write or pop to that warp (write dropped, no err_overflow).
REQ-028 SHALL keep FIFO pointers $clog2(DEPTH) bits with natural wrap-around and count $clog2(DEPTH+1) bits.
REQ-029 SHALL derive warp_full[w] = (count[w] == DEPTH) and warp_empty[w] = (count[w] == 0) from registered counts.
REQ-030 SHALL with rdy low ignore in_valid, flush_valid, and out_ready, force out_valid to 0, and change no state.

Reset
REQ-031 SHALL on rst clear all counts and pointers, set rr_ptr = NUM_WARPS-1 (warp 0 first priority), and clear err_overflow.
REQ-032 SHALL after reset drive out_valid=0, warp_empty all ones, and warp_full all zeros; reset SHALL override rdy and discard in-flight entries.

Structure
REQ-033 SHALL take inst_t, NUM_WARPS, and the warp-number width from gelato_types; no new package types are needed.
REQ-034 SHALL instantiate NUM_WARPS copies of sub-module gelato_warp_fifo (write, pop, flush, head, count).

Verification
REQ-035 Write 3 insts to warp 1, warp_ready=all, out_ready=1 -> out_valid from cycle after the first write; pcs emerge in order; warp_empty[1]=1 after.
REQ-036 Fill warp 0 with 4 entries, out_ready=0 -> warp_full[0]=1; a 5th write -> dropped, err_overflow=1, count stays 4.
REQ-037 Warp 0 full, out_ready=1, write warp 0 in the same cycle -> write accepted, warp_full[0] stays 1, no error.
REQ-038 Warps 0,1,2 each hold 2 entries, all ready -> grant order 0,1,2,0,1,2.
REQ-039 Warp 2 holds 3 entries, flush_warp=2 with a same-cycle write and pop to warp 2 -> warp 2 empty, no pop, no error.
REQ-040 warp_ready[1]=0 with warp 1 non-empty, warp 3 non-empty -> only warp 3 issued; raising warp_ready[1] -> warp 1 issued next.
